matmul_dma: RTL and testbench

MATMUL_DMA -- requirements
Module: matmul_dma

---
 rtl/matmul_dma_if.sv | 43 ++++
 rtl/matmul_dma.sv | 131 +++++++++++++
 tb/tb_matmul_dma.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matmul_dma_if.sv
// Bundle of the streaming, memory-port and status signals between matmul_dma and its surroundings.
// slave is the DMA side, master is the environment (source, memories, compute core, sink).
interface matmul_dma_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;

  logic                  x_wr_en;
  logic [ADDR_WIDTH-1:0] x_addr;
  logic [DATA_WIDTH-1:0] x_din;
  logic                  y_wr_en;
  logic [ADDR_WIDTH-1:0] y_addr;
  logic [DATA_WIDTH-1:0] y_din;

  logic                  mm_start;
  logic                  mm_done;

  logic [ADDR_WIDTH-1:0] z_addr;
  logic [DATA_WIDTH-1:0] z_dout;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;

  logic                  busy;
  logic                  frame_done;

  modport slave (
    input  in_valid, in_data, mm_done, z_dout, out_ready,
    output in_ready, x_wr_en, x_addr, x_din, y_wr_en, y_addr, y_din,
           mm_start, z_addr, out_valid, out_data, out_last, busy, frame_done
  );

  modport master (
    output in_valid, in_data, mm_done, z_dout, out_ready,
    input  in_ready, x_wr_en, x_addr, x_din, y_wr_en, y_addr, y_din,
           mm_start, z_addr, out_valid, out_data, out_last, busy, frame_done
  );
endinterface

// File: rtl/matmul_dma.sv
// Streams x then y into the operand memories, kicks the matrix multiplier, then
// drains the z memory through a 2-entry skid FIFO onto the result stream.
//
// state  | meaning
// LOAD_X | accept NUM_ELEMS beats into x memory
// LOAD_Y | accept NUM_ELEMS beats into y memory
// START  | one-cycle mm_start pulse
// WAIT   | wait for a rising edge on mm_done
// UNLOAD | read z in order and stream it out, last beat ends the frame
module matmul_dma #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 6,
  parameter int VECTOR_SIZE = 8
) (
  input  logic           clock,
  input  logic           reset,
  matmul_dma_if.slave    bus
);
  localparam int NUM_ELEMS = VECTOR_SIZE * VECTOR_SIZE;
  localparam logic [6:0] CNT_END  = 7'(NUM_ELEMS);
  localparam logic [6:0] CNT_LAST = 7'(NUM_ELEMS - 1);

  typedef enum logic [2:0] {LOAD_X, LOAD_Y, START, WAIT, UNLOAD} state_t;

  state_t                state;
  logic [6:0]            cnt;
  logic                  done_q;
  logic                  rd_pend;
  logic                  rd_pend_last;
  logic [DATA_WIDTH-1:0] fifo_data [2];
  logic                  fifo_last [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            occ;
  logic                  frame_done_q;

  logic                  accept;
  logic                  pop;
  logic                  issue;
  logic                  head_last;
  logic [1:0]            occ_after;

  // The beat popped this cycle frees its slot, so a full-rate stream keeps issuing.
  always_comb begin
    bus.in_ready = (state == LOAD_X) || (state == LOAD_Y);
    accept       = bus.in_valid && bus.in_ready && !reset;
    bus.x_wr_en  = accept && (state == LOAD_X);
    bus.y_wr_en  = accept && (state == LOAD_Y);
    bus.x_addr   = bus.x_wr_en ? cnt[ADDR_WIDTH-1:0] : '0;
    bus.y_addr   = bus.y_wr_en ? cnt[ADDR_WIDTH-1:0] : '0;
    bus.x_din    = bus.x_wr_en ? bus.in_data : '0;
    bus.y_din    = bus.y_wr_en ? bus.in_data : '0;
    bus.mm_start = (state == START);

    head_last     = fifo_last[rd_ptr];
    bus.out_valid = (occ != 2'd0);
    bus.out_data  = bus.out_valid ? fifo_data[rd_ptr] : '0;
    bus.out_last  = bus.out_valid && head_last;
    pop           = bus.out_valid && bus.out_ready;

    occ_after  = occ - {1'b0, pop};
    issue      = (state == UNLOAD) && (cnt < CNT_END) &&
                 ((occ_after + {1'b0, rd_pend}) < 2'd2);
    bus.z_addr = issue ? cnt[ADDR_WIDTH-1:0] : '0;

    bus.busy       = !((state == LOAD_X) && (cnt == 7'd0));
    bus.frame_done = frame_done_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= LOAD_X;
      cnt          <= '0;
      done_q       <= 1'b0;
      rd_pend      <= 1'b0;
      rd_pend_last <= 1'b0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      occ          <= '0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
    end else begin
      done_q       <= bus.mm_done;
      frame_done_q <= 1'b0;
      rd_pend      <= issue;
      rd_pend_last <= issue && (cnt == CNT_LAST);

      if (rd_pend) begin
        fifo_data[wr_ptr] <= bus.z_dout;
        fifo_last[wr_ptr] <= rd_pend_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, rd_pend} - {1'b0, pop};

      case (state)
        LOAD_X: if (accept) begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= LOAD_Y;
          end else begin
            cnt <= cnt + 7'd1;
          end
        end
        LOAD_Y: if (accept) begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= START;
          end else begin
            cnt <= cnt + 7'd1;
          end
        end
        START:  state <= WAIT;
        // A level left high from an earlier frame must not count as completion.
        WAIT:   if (bus.mm_done && !done_q) state <= UNLOAD;
        UNLOAD: begin
          if (issue) cnt <= cnt + 7'd1;
          if (pop && head_last) begin
            cnt          <= '0;
            state        <= LOAD_X;
            frame_done_q <= 1'b1;
          end
        end
        default: state <= LOAD_X;
      endcase
    end
  end
endmodule

// File: tb/tb_matmul_dma.sv
// Randomised scoreboard bench for matmul_dma: expected memory writes and result
// beats are queued from a plain reference of the frame and checked by a monitor.
module tb_matmul_dma;
  localparam int DW = 32;
  localparam int AW = 6;
  localparam int VS = 8;
  localparam int NE = VS * VS;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic clock = 1'b0;
  logic reset = 1'b0;

  matmul_dma_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  matmul_dma #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .VECTOR_SIZE(VS)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  int          errors = 0;
  int          checks = 0;
  longint      cyc = 0;
  int          ready_mode = 0;
  int          start_pulses = 0;
  logic [DW-1:0] zmem [NE];
  wr_t         x_exp [$];
  wr_t         y_exp [$];
  beat_t       o_exp [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // z memory: synchronous read, data one cycle after the address
  always @(posedge clock) bus.z_dout <= zmem[bus.z_addr];

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  initial begin
    bit ready_pat [4];
    int phase;
    ready_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    phase = 0;
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      case (ready_mode)
        0: bus.out_ready = 1'b1;
        1: begin
          bus.out_ready = ready_pat[phase % 4];
          phase++;
        end
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // monitor
  initial begin
    wr_t           e;
    beat_t         b;
    logic          stalled;
    logic          expect_fd;
    logic [DW-1:0] held_d;
    logic          held_l;
    int            beat_idx;
    longint        first_cyc;
    stalled = 1'b0;
    expect_fd = 1'b0;
    held_d = '0;
    held_l = 1'b0;
    beat_idx = 0;
    first_cyc = 0;
    forever begin
      @(negedge clock);
      if (bus.x_wr_en) begin
        if (x_exp.size() == 0) chk("x_unexpected_write", bus.x_wr_en, 0);
        else begin
          e = x_exp.pop_front();
          chk("x_addr", bus.x_addr, e.addr);
          chk("x_din", bus.x_din, e.data);
        end
      end
      if (bus.y_wr_en) begin
        if (y_exp.size() == 0) chk("y_unexpected_write", bus.y_wr_en, 0);
        else begin
          e = y_exp.pop_front();
          chk("y_addr", bus.y_addr, e.addr);
          chk("y_din", bus.y_din, e.data);
        end
      end
      if (bus.mm_start) start_pulses++;
      if (expect_fd) begin
        chk("frame_done_pulse", bus.frame_done, 1);
        expect_fd = 1'b0;
      end else if (bus.frame_done) begin
        chk("frame_done_spurious", bus.frame_done, 0);
      end
      if (stalled) begin
        chk("stall_valid", bus.out_valid, 1);
        chk("stall_data", bus.out_data, held_d);
        chk("stall_last", bus.out_last, held_l);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (o_exp.size() == 0) chk("out_unexpected_beat", bus.out_valid, 0);
        else begin
          b = o_exp.pop_front();
          chk("out_data", bus.out_data, b.data);
          chk("out_last", bus.out_last, b.last);
          if (beat_idx == 0) first_cyc = cyc;
          beat_idx++;
          if (b.last) begin
            expect_fd = 1'b1;
            if (ready_mode == 0) chk("sustain_span", 64'(cyc - first_cyc), NE - 1);
            beat_idx = 0;
          end
        end
      end
      stalled = bus.out_valid && !bus.out_ready;
      held_d  = bus.out_data;
      held_l  = bus.out_last;
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    chk({tag, "_x_wr_en"}, bus.x_wr_en, 0);
    chk({tag, "_y_wr_en"}, bus.y_wr_en, 0);
    chk({tag, "_x_addr"}, bus.x_addr, 0);
    chk({tag, "_x_din"}, bus.x_din, 0);
    chk({tag, "_y_addr"}, bus.y_addr, 0);
    chk({tag, "_y_din"}, bus.y_din, 0);
    chk({tag, "_z_addr"}, bus.z_addr, 0);
    chk({tag, "_mm_start"}, bus.mm_start, 0);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out_last"}, bus.out_last, 0);
    chk({tag, "_out_data"}, bus.out_data, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_frame_done"}, bus.frame_done, 0);
  endtask

  task automatic drive_beat(input int i, input logic [DW-1:0] w);
    wr_t e;
    e.addr = AW'(i % NE);
    e.data = w;
    if (i < NE) x_exp.push_back(e);
    else y_exp.push_back(e);
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    @(posedge clock);
    #1;
  endtask

  // mode 0: counting data, z=i*3, full-rate sink, stale mm_done
  // mode 1: random data with gaps, sink ready pattern 1,0,0,1
  // mode 2: random data with gaps, random sink ready
  task automatic run_frame(input int mode);
    beat_t b;
    int    k;
    ready_mode   = mode;
    start_pulses = 0;
    for (int i = 0; i < NE; i++) begin
      zmem[i] = (mode == 0) ? DW'(i * 3) : DW'($urandom);
      b.data = zmem[i];
      b.last = (i == NE - 1);
      o_exp.push_back(b);
    end
    bus.mm_done = (mode == 0);
    for (int i = 0; i < 2 * NE; i++) begin
      if (mode != 0) begin
        while ($urandom_range(0, 2) == 0) begin
          bus.in_valid = 1'b0;
          bus.in_data  = DW'($urandom);
          @(posedge clock);
          #1;
        end
      end
      drive_beat(i, (mode == 0) ? DW'(i) : DW'($urandom));
    end
    bus.in_valid = (mode != 0);
    bus.in_data  = DW'($urandom);
    chk("mm_start_after_last_beat", bus.mm_start, 1);
    chk("in_ready_low_in_start", bus.in_ready, 0);
    @(posedge clock);
    #1;
    chk("mm_start_single_cycle", bus.mm_start, 0);
    if (mode == 0) begin
      repeat (3) begin
        @(posedge clock);
        #1;
      end
      chk("stale_done_no_unload", bus.out_valid, 0);
      bus.mm_done = 1'b0;
      repeat (20) begin
        @(posedge clock);
        #1;
      end
      chk("done_low_no_unload", bus.out_valid, 0);
    end else begin
      repeat (5) begin
        @(posedge clock);
        #1;
      end
    end
    bus.mm_done = 1'b1;
    k = 0;
    do begin
      @(posedge clock);
      #1;
      k++;
    end while (!bus.out_valid && k < 10);
    chk("first_valid_latency", 64'(k), 3);
    k = 0;
    while (!bus.frame_done && k < 2000) begin
      @(posedge clock);
      #1;
      k++;
    end
    bus.in_valid = 1'b0;
    bus.mm_done  = 1'b0;
    chk("frame_done_seen", bus.frame_done, 1);
    chk("busy_idle_after_frame", bus.busy, 0);
    chk("mm_start_pulse_count", 64'(start_pulses), 1);
    chk("out_queue_drained", 64'(o_exp.size()), 0);
    chk("x_queue_drained", 64'(x_exp.size()), 0);
    chk("y_queue_drained", 64'(y_exp.size()), 0);
  endtask

  initial begin
    bus.in_valid = 1'b1;
    bus.in_data  = DW'($urandom);
    bus.mm_done  = 1'b0;
    #2 reset = 1'b1;
    #1 check_reset_outputs("reset_initial");
    bus.in_valid = 1'b0;
    #19 reset = 1'b0;
    @(posedge clock);
    #1;
    chk("busy_idle_after_reset", bus.busy, 0);

    run_frame(0);
    run_frame(1);

    // abort mid-frame: 64 x beats plus 6 y beats, then reset
    for (int i = 0; i < 70; i++) drive_beat(i, DW'($urandom));
    chk("busy_mid_frame", bus.busy, 1);
    bus.in_valid = 1'b1;
    bus.in_data  = DW'($urandom);
    #2 reset = 1'b1;
    #1 check_reset_outputs("reset_mid_frame");
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clock);
    #2 reset = 1'b0;
    @(posedge clock);
    #1;

    run_frame(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion before it");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog expired");
  end
endmodule
